// File: rtl/mem_responder_pipe.sv
// Fixed-latency pipelined memory responder: one request per cycle, reads return LATENCY cycles later.
// Optional misalignment checking and err port enabled by defining ADDR_ALIGN_CHK_EN.
module mem_responder_pipe #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
`ifdef ADDR_ALIGN_CHK_EN
  ,
  output logic        err
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0]        r_mem [DEPTH];
  logic [LATENCY-1:0] r_vld;
  logic [15:0]        r_dat [LATENCY];

  logic [ADDR_W-1:0]  w_idx;
  logic               w_mis;
  logic               w_rdAcc;
  logic               w_wrAcc;
  logic               w_unused;

  assign w_idx    = addr[ADDR_W:1];
  assign w_unused = ^{addr[15:ADDR_W+1], addr[0]};

`ifdef ADDR_ALIGN_CHK_EN
  assign w_mis = addr[0];
`else
  assign w_mis = 1'b0;
`endif

  // Misaligned writes are dropped; misaligned reads still occupy a pipeline slot.
  assign w_rdAcc = enable & ~wr;
  assign w_wrAcc = enable & wr & ~w_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wrAcc) begin
      r_mem[w_idx] <= data_in;
    end
  end

  // Data is zeroed in empty slots so the output stage can drive data_out directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_dat[i] <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
      r_vld[0] <= w_rdAcc;
      r_dat[0] <= (w_rdAcc && !w_mis) ? r_mem[w_idx] : 16'h0000;
    end
  end

  assign data_out   = r_dat[LATENCY-1];
  assign data_valid = r_vld[LATENCY-1];
  assign busy       = |r_vld;

`ifdef ADDR_ALIGN_CHK_EN
  logic [LATENCY-1:0] r_err;
  logic               r_wrErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err   <= '0;
      r_wrErr <= 1'b0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) r_err[i] <= r_err[i-1];
      r_err[0] <= w_rdAcc & w_mis;
      r_wrErr  <= enable & wr & w_mis;
    end
  end

  assign err = r_err[LATENCY-1] | r_wrErr;
`endif

endmodule

// File: tb/tb_mem_responder_pipe.sv
// Bench for mem_responder_pipe: queue-based response model checked every cycle plus directed literal checks.
// Define ADDR_ALIGN_CHK_EN to exercise the misalignment feature.
module tb_mem_responder_pipe;

  localparam int LAT = 4;
  localparam int AW  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        errObs;

  int passCount = 0;
  int checkCount = 0;

  mem_responder_pipe #(.LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .wr(wr),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out),
    .data_valid(data_valid),
    .busy(busy)
`ifdef ADDR_ALIGN_CHK_EN
    ,
    .err(errObs)
`endif
  );

`ifndef ADDR_ALIGN_CHK_EN
  assign errObs = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        err;
  } resp_t;

  // Model: each accepted read is scheduled to appear at a fixed edge count from its acceptance.
  resp_t       expQ[$];
  logic [15:0] mMem [0:(1<<AW)-1];
  int          cnt = 0;
  int          werrCyc = -100;
  int          lastAcceptCyc = 0;

  logic [15:0] gotQ[$];
  int          gotCyc[$];
  logic        gotErr[$];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cnt);
  endtask

  task automatic modelClear();
    expQ.delete();
    werrCyc = -100;
    for (int i = 0; i < (1 << AW); i++) mMem[i] = 16'h0000;
  endtask

  always @(negedge rst_n) modelClear();

  always @(posedge clk) begin
    int     idx;
    logic   mis;
    resp_t  r;
    cnt++;
    if (rst_n && enable) begin
      idx = int'(addr[AW:1]);
`ifdef ADDR_ALIGN_CHK_EN
      mis = addr[0];
`else
      mis = 1'b0;
`endif
      if (wr) begin
        if (mis) werrCyc = cnt;
        else mMem[idx] = data_in;
      end else begin
        r.due  = cnt + LAT - 1;
        r.data = mis ? 16'h0000 : mMem[idx];
        r.err  = mis;
        expQ.push_back(r);
        lastAcceptCyc = cnt;
      end
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic        expV;
    logic [15:0] expD;
    logic        expE;
    expV = (expQ.size() > 0) && (expQ[0].due == cnt);
    expD = expV ? expQ[0].data : 16'h0000;
    expE = (expV && expQ[0].err) || (werrCyc == cnt);
    checkOutput("data_valid", {31'b0, data_valid}, {31'b0, expV});
    checkOutput("data_out", {16'b0, data_out}, {16'b0, expD});
    checkOutput("busy", {31'b0, busy}, {31'b0, expQ.size() > 0});
`ifdef ADDR_ALIGN_CHK_EN
    checkOutput("err", {31'b0, errObs}, {31'b0, expE});
`endif
    if (data_valid === 1'b1) begin
      gotQ.push_back(data_out);
      gotCyc.push_back(cnt);
      gotErr.push_back(errObs);
    end
    if (expV) void'(expQ.pop_front());
  end

  task automatic applyStimulus(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    #1;
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic clearLog();
    gotQ.delete();
    gotCyc.delete();
    gotErr.delete();
  endtask

  initial begin
    modelClear();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    checkOutput("resetValid", {31'b0, data_valid}, 32'd0);
    checkOutput("resetData", {16'b0, data_out}, 32'd0);
    checkOutput("resetBusy", {31'b0, busy}, 32'd0);

    // Read of a freshly cleared word.
    clearLog();
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(7);
    checkOutput("t1Count", gotQ.size(), 32'd1);
    if (gotQ.size() == 1) begin
      checkOutput("t1Data", {16'b0, gotQ[0]}, 32'h0000);
      checkOutput("t1Latency", gotCyc[0] - lastAcceptCyc, 32'd3);
    end

    // Read-after-write on the next cycle.
    clearLog();
    applyStimulus(1'b1, 1'b1, 16'h0020, 16'hBEEF);
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(7);
    checkOutput("t2Count", gotQ.size(), 32'd1);
    if (gotQ.size() == 1) checkOutput("t2Data", {16'b0, gotQ[0]}, 32'h0000BEEF);

    // Streaming reads return in order, without bubbles.
    clearLog();
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h1111);
    applyStimulus(1'b1, 1'b1, 16'h0002, 16'h2222);
    applyStimulus(1'b1, 1'b1, 16'h0004, 16'h3333);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0004, 16'h0000);
    idle(7);
    checkOutput("t3Count", gotQ.size(), 32'd3);
    if (gotQ.size() == 3) begin
      checkOutput("t3Data0", {16'b0, gotQ[0]}, 32'h00001111);
      checkOutput("t3Data1", {16'b0, gotQ[1]}, 32'h00002222);
      checkOutput("t3Data2", {16'b0, gotQ[2]}, 32'h00003333);
      checkOutput("t3Gap", gotCyc[2] - gotCyc[0], 32'd2);
    end

    // Write behind an in-flight read does not disturb it.
    applyStimulus(1'b1, 1'b1, 16'h0030, 16'hAAAA);
    clearLog();
    applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'h0030, 16'h5555);
    idle(7);
    applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0000);
    idle(7);
    checkOutput("t4Count", gotQ.size(), 32'd2);
    if (gotQ.size() == 2) begin
      checkOutput("t4Old", {16'b0, gotQ[0]}, 32'h0000AAAA);
      checkOutput("t4New", {16'b0, gotQ[1]}, 32'h00005555);
    end

    // Upper address bits beyond the word index are ignored (0xF820 aliases word of 0x0020).
    clearLog();
    applyStimulus(1'b1, 1'b0, 16'hF820, 16'h0000);
    idle(7);
    checkOutput("aliasCount", gotQ.size(), 32'd1);
    if (gotQ.size() == 1) checkOutput("aliasData", {16'b0, gotQ[0]}, 32'h0000BEEF);

`ifndef ADDR_ALIGN_CHK_EN
    // Without alignment checking, addr[0] is ignored.
    clearLog();
    applyStimulus(1'b1, 1'b0, 16'h0021, 16'h0000);
    idle(7);
    checkOutput("oddCount", gotQ.size(), 32'd1);
    if (gotQ.size() == 1) checkOutput("oddData", {16'b0, gotQ[0]}, 32'h0000BEEF);
`endif

    // Reset with reads in flight discards them and clears the array.
    clearLog();
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000);
    @(negedge clk);
    #1;
    enable = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstValid", {31'b0, data_valid}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(7);
    checkOutput("rstNoResp", gotQ.size(), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
    idle(7);
    checkOutput("rstArrCount", gotQ.size(), 32'd1);
    if (gotQ.size() == 1) checkOutput("rstArrData", {16'b0, gotQ[0]}, 32'h0000);

`ifdef ADDR_ALIGN_CHK_EN
    // Misaligned write is dropped and flags err for one cycle; misaligned read returns zero with err.
    clearLog();
    applyStimulus(1'b1, 1'b1, 16'h0041, 16'h7777);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("misWrErr", {31'b0, errObs}, 32'd1);
    idle(1);
    checkOutput("misWrErrOff", {31'b0, errObs}, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0041, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000);
    idle(7);
    checkOutput("misCount", gotQ.size(), 32'd2);
    if (gotQ.size() == 2) begin
      checkOutput("misRdData", {16'b0, gotQ[0]}, 32'h0000);
      checkOutput("misRdErr", {31'b0, gotErr[0]}, 32'd1);
      checkOutput("alnRdData", {16'b0, gotQ[1]}, 32'h0000);
      checkOutput("alnRdErr", {31'b0, gotErr[1]}, 32'd0);
    end
`endif

    idle(2);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_responder_pipe.md
Name: mem_responder_pipe

Overview:
- Pipelined, fixed-latency memory responder: the memory end of the CPU's data/instruction memory port (enable / wr / addr / data_in in, data_out back).
- Models a multi-cycle main memory for the upcoming cache stage.
- Accepts one request per cycle and returns read data exactly LATENCY cycles later, with an explicit valid strobe.
- Up to LATENCY reads may be in flight at once.

Parameters:
- LATENCY, 4, cycles from read acceptance to data_valid; legal range 1..8, 0 illegal.
- ADDR_W, 10, word-index width; array depth = 2^ADDR_W 16-bit words.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  request present this cycle.
- wr  input  1  1 = write, 0 = read; sampled only when enable=1.
- addr  input  16  byte address; word index = addr[ADDR_W:1]; addr[0] and addr[15:ADDR_W+1] ignored.
- data_in  input  16  write data.
- data_out  output  16  read data; 16'h0000 whenever data_valid=0.
- data_valid  output  1  one-cycle strobe per completed read.
- busy  output  1  1 while any read is in flight or completing.
- err  output  1  misalignment flag; present only with ADDR_ALIGN_CHK_EN.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valid bits cleared; data_valid=0, data_out=0, busy=0, err=0; array cleared to 16'h0000. Held while rst_n low.
- Acceptance: a request is accepted at a rising edge where rst_n=1 and enable=1. enable=0 means no effect; wr, addr and data_in are don't-care. There is no back-pressure: every enabled cycle is accepted.
- Write: array word updated at the accepting edge. No response strobe; data_valid is never asserted for a write.
- Read: array word sampled at the accepting edge N, then carried through a LATENCY-deep valid/data shift pipeline. data_valid=1 with that word on data_out during the cycle following edge N+LATENCY-1, for exactly one cycle.
- LATENCY=1: data is visible the cycle after the request, matching the single-cycle memory timing.
- Ordering: responses return strictly in request order. Back-to-back reads on consecutive cycles give back-to-back data_valid cycles with no bubbles.
- Read-after-write: a read accepted after a write to the same word returns the new data, including a read on the very next cycle.
- A write to a word with a read already in flight does not alter that read's data; the read was captured at acceptance.
- Reads and writes may interleave freely; writes occupy no pipeline slot (the slot carries valid=0).
- busy = OR of all pipeline valid bits, including the output stage. It is combinationally derived from registered state only; it does not depend on current inputs.
- Reset mid-operation: all in-flight reads are discarded; no data_valid is issued for them after rst_n rises.
- Array writes issued before the reset are lost, because the array is cleared.
- First acceptance is possible at the first rising edge with rst_n=1.

Optional Feature:
- Macro: ADDR_ALIGN_CHK_EN.
- Defined:
  - An accepted request with addr[0]=1 is flagged as misaligned.
  - A misaligned write is dropped (array unchanged).
  - A misaligned read travels the pipeline normally, but completes with data_out=16'h0000 and err=1 in its data_valid cycle.
  - A misaligned write sets err=1 for the single cycle after acceptance.
  - err is otherwise 0 and cleared by reset.
- Undefined:
  - No err port.
  - addr[0] is ignored entirely; the access goes to word addr[ADDR_W:1].

Test Plan:
- Reset then read: rst_n low 3 cycles, release; read addr 16'h0010 -> data_valid exactly 4 cycles later with data_out=16'h0000, busy high for those 4 cycles.
- Write then read: write 16'hBEEF to 16'h0020, next cycle read 16'h0020 -> data_valid 4 cycles after the read with data_out=16'hBEEF.
- Streaming: write 16'h1111, 16'h2222, 16'h3333 to 16'h0000, 16'h0002, 16'h0004, then read all three on consecutive cycles -> three consecutive data_valid cycles returning 1111, 2222, 3333 in order.
- Write behind read: read 16'h0030 (holds 16'hAAAA), next cycle write 16'h5555 to 16'h0030 -> response data 16'hAAAA; a later read returns 16'h5555.
- Mid-flight reset: issue two reads, assert rst_n low 2 cycles after the first -> no data_valid ever appears; busy=0 immediately on reset; a read of a previously written word returns 16'h0000.
- ADDR_ALIGN_CHK_EN: write 16'h7777 to 16'h0041 -> err=1 one cycle, array unchanged; read 16'h0041 -> data_valid with data_out=0 and err=1; read 16'h0040 -> 16'h0000, err=0.
